// File: rtl/conflict_free_read_unmap.sv
// Read return path for the conflict-free coefficient memory mapper.
// Delays the mapper's per-lane bank tags by the bank RAM read latency, then
// routes the four bank read words back to lane order and rebuilds each lane's
// 7-bit logical coefficient address. A sticky flag records any valid beat in
// which two lanes targeted the same bank.
module conflict_free_read_unmap #(
    parameter int DATA_WIDTH  = 12,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [1:0]            bank_number_0,
    input  logic [1:0]            bank_number_1,
    input  logic [1:0]            bank_number_2,
    input  logic [1:0]            bank_number_3,
    input  logic [4:0]            new_address_0,
    input  logic [4:0]            new_address_1,
    input  logic [4:0]            new_address_2,
    input  logic [4:0]            new_address_3,
    input  logic [DATA_WIDTH-1:0] bank_rdata_0,
    input  logic [DATA_WIDTH-1:0] bank_rdata_1,
    input  logic [DATA_WIDTH-1:0] bank_rdata_2,
    input  logic [DATA_WIDTH-1:0] bank_rdata_3,
    input  logic                  clear_conflict,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] lane_data_0,
    output logic [DATA_WIDTH-1:0] lane_data_1,
    output logic [DATA_WIDTH-1:0] lane_data_2,
    output logic [DATA_WIDTH-1:0] lane_data_3,
    output logic [6:0]            old_address_0,
    output logic [6:0]            old_address_1,
    output logic [6:0]            old_address_2,
    output logic [6:0]            old_address_3,
    output logic                  conflict
);

    logic [1:0]            bank_in   [4];
    logic [4:0]            addr_in   [4];
    logic [DATA_WIDTH-1:0] rdata     [4];

    logic                  pipe_valid [MEM_LATENCY];
    logic [1:0]            pipe_bank  [MEM_LATENCY][4];
    logic [4:0]            pipe_addr  [MEM_LATENCY][4];

    logic                  leave_valid;
    logic [1:0]            leave_bank [4];
    logic [4:0]            leave_addr [4];
    logic [1:0]            leave_low  [4];

    logic [DATA_WIDTH-1:0] lane_q     [4];
    logic [6:0]            old_q      [4];
    logic                  dup_bank;

    assign bank_in[0] = bank_number_0;
    assign bank_in[1] = bank_number_1;
    assign bank_in[2] = bank_number_2;
    assign bank_in[3] = bank_number_3;
    assign addr_in[0] = new_address_0;
    assign addr_in[1] = new_address_1;
    assign addr_in[2] = new_address_2;
    assign addr_in[3] = new_address_3;
    assign rdata[0]   = bank_rdata_0;
    assign rdata[1]   = bank_rdata_1;
    assign rdata[2]   = bank_rdata_2;
    assign rdata[3]   = bank_rdata_3;

    assign lane_data_0   = lane_q[0];
    assign lane_data_1   = lane_q[1];
    assign lane_data_2   = lane_q[2];
    assign lane_data_3   = lane_q[3];
    assign old_address_0 = old_q[0];
    assign old_address_1 = old_q[1];
    assign old_address_2 = old_q[2];
    assign old_address_3 = old_q[3];

    // Tag shift register; advances every cycle since the RAM cannot stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < MEM_LATENCY; s++) begin
                pipe_valid[s] <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    pipe_bank[s][i] <= 2'd0;
                    pipe_addr[s][i] <= 5'd0;
                end
            end
        end else begin
            pipe_valid[0] <= in_valid;
            for (int i = 0; i < 4; i++) begin
                pipe_bank[0][i] <= bank_in[i];
                pipe_addr[0][i] <= addr_in[i];
            end
            for (int s = 1; s < MEM_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                for (int i = 0; i < 4; i++) begin
                    pipe_bank[s][i] <= pipe_bank[s-1][i];
                    pipe_addr[s][i] <= pipe_addr[s-1][i];
                end
            end
        end
    end

    assign leave_valid = pipe_valid[MEM_LATENCY-1];

    // Inverse of bank = {parity(addr[6:2]), 0} + addr[1:0], wrapping mod 4.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            leave_bank[i] = pipe_bank[MEM_LATENCY-1][i];
            leave_addr[i] = pipe_addr[MEM_LATENCY-1][i];
            leave_low[i]  = leave_bank[i] - {^leave_addr[i], 1'b0};
        end
    end

    // Unmap stage: lanes pick their bank word when the arriving tag is valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= '0;
                old_q[i]  <= 7'd0;
            end
        end else if (leave_valid) begin
            out_valid <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= rdata[leave_bank[i]];
                old_q[i]  <= {leave_addr[i], leave_low[i]};
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Any two lanes on the same bank in the incoming beat.
    always_comb begin
        dup_bank = (bank_in[0] == bank_in[1]) || (bank_in[0] == bank_in[2]) ||
                   (bank_in[0] == bank_in[3]) || (bank_in[1] == bank_in[2]) ||
                   (bank_in[1] == bank_in[3]) || (bank_in[2] == bank_in[3]);
    end

    // Sticky conflict flag; a new conflict outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict <= 1'b0;
        end else if (in_valid && dup_bank) begin
            conflict <= 1'b1;
        end else if (clear_conflict) begin
            conflict <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conflict_free_read_unmap.sv
// Bench for conflict_free_read_unmap: three instances (read latency 1, 2, 3)
// share one stimulus stream and one physical bank RAM image.
module tb_conflict_free_read_unmap;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        clear;
    logic [1:0]  bank [4];
    logic [4:0]  na   [4];

    logic [11:0] phys [4][32];
    logic [4:0]  raddr [4];
    logic [4:0]  hist  [3][4];
    logic [11:0] rd    [3][4];

    logic        ov [3];
    logic [11:0] ld [3][4];
    logic [6:0]  oa [3][4];
    logic        cf [3];

    logic        exp_v  [3];
    logic [11:0] exp_d  [3][4];
    logic [6:0]  exp_a  [3][4];
    logic        exp_ov [3];
    logic [11:0] held_d [3][4];
    logic [6:0]  held_a [3][4];
    logic        exp_cf;

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        conflict_free_read_unmap #(.DATA_WIDTH(12), .MEM_LATENCY(g + 1)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid),
            .bank_number_0(bank[0]), .bank_number_1(bank[1]),
            .bank_number_2(bank[2]), .bank_number_3(bank[3]),
            .new_address_0(na[0]), .new_address_1(na[1]),
            .new_address_2(na[2]), .new_address_3(na[3]),
            .bank_rdata_0(rd[g][0]), .bank_rdata_1(rd[g][1]),
            .bank_rdata_2(rd[g][2]), .bank_rdata_3(rd[g][3]),
            .clear_conflict(clear),
            .out_valid(ov[g]),
            .lane_data_0(ld[g][0]), .lane_data_1(ld[g][1]),
            .lane_data_2(ld[g][2]), .lane_data_3(ld[g][3]),
            .old_address_0(oa[g][0]), .old_address_1(oa[g][1]),
            .old_address_2(oa[g][2]), .old_address_3(oa[g][3]),
            .conflict(cf[g])
        );
    end

    // Forward mapping used by the mapper: logical address -> bank.
    function automatic logic [1:0] fwd_bank(input logic [6:0] x);
        logic [1:0] r;
        r = {^x[6:2], 1'b0} + x[1:0];
        return r;
    endfunction

    // The bank RAM is addressed by the last lane that targets it.
    function automatic logic [4:0] sel_addr(input logic [1:0] b);
        logic [4:0] r;
        r = 5'd0;
        for (int j = 0; j < 4; j++)
            if (bank[j] == b) r = na[j];
        return r;
    endfunction

    function automatic logic [11:0] model_data(input int i);
        return phys[bank[i]][sel_addr(bank[i])];
    endfunction

    // Search for the logical address that the mapper sent to (bank, na).
    function automatic logic [6:0] model_old(input int i);
        logic [6:0] r;
        logic [6:0] xv;
        r = 7'd0;
        for (int x = 0; x < 128; x++) begin
            xv = 7'(x);
            if (fwd_bank(xv) == bank[i] && xv[6:2] == na[i]) r = xv;
        end
        return r;
    endfunction

    function automatic logic has_dup();
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (bank[i] == bank[j]) r = 1'b1;
        return r;
    endfunction

    // Load the RAM image from a logical data map; mode 0 adds the directed overrides.
    task automatic fill(input int mode);
        logic [6:0]  xv;
        logic [11:0] dv;
        for (int x = 0; x < 128; x++) begin
            xv = 7'(x);
            dv = 12'(x * 3);
            if (mode == 0) begin
                case (x)
                    0: dv = 12'hA00;
                    1: dv = 12'hB11;
                    2: dv = 12'hC22;
                    3: dv = 12'hD33;
                    6: dv = 12'h100;
                    7: dv = 12'h200;
                    4: dv = 12'h300;
                    5: dv = 12'h400;
                    default: ;
                endcase
            end
            phys[fwd_bank(xv)][xv[6:2]] = dv;
        end
    endtask

    always_comb begin
        for (int b = 0; b < 4; b++) raddr[b] = sel_addr(2'(b));
    end

    always_comb begin
        for (int g = 0; g < 3; g++)
            for (int b = 0; b < 4; b++)
                rd[g][b] = phys[b][hist[g][b]];
    end

    // Bank RAM read-address history: instance g sees data for addresses g+1 edges old.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            hist[0][b] <= raddr[b];
            hist[1][b] <= hist[0][b];
            hist[2][b] <= hist[1][b];
        end
    end

    // Reference model: beat records aged by edge count, held outputs, sticky flag.
    always @(posedge clk) begin
        if (!rst) begin
            exp_cf <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                exp_v[k]  <= 1'b0;
                exp_ov[k] <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    held_d[k][i] <= 12'd0;
                    held_a[k][i] <= 7'd0;
                end
            end
        end else begin
            exp_v[0] <= in_valid;
            for (int i = 0; i < 4; i++) begin
                exp_d[0][i] <= model_data(i);
                exp_a[0][i] <= model_old(i);
            end
            for (int k = 1; k < 3; k++) begin
                exp_v[k] <= exp_v[k-1];
                for (int i = 0; i < 4; i++) begin
                    exp_d[k][i] <= exp_d[k-1][i];
                    exp_a[k][i] <= exp_a[k-1][i];
                end
            end
            for (int g = 0; g < 3; g++) begin
                exp_ov[g] <= exp_v[g];
                if (exp_v[g]) begin
                    for (int i = 0; i < 4; i++) begin
                        held_d[g][i] <= exp_d[g][i];
                        held_a[g][i] <= exp_a[g][i];
                    end
                end
            end
            if (in_valid && has_dup()) exp_cf <= 1'b1;
            else if (clear) exp_cf <= 1'b0;
        end
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", nm, g, act, expv);
        end
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            chk("out_valid", g, 32'(ov[g]), 32'(exp_ov[g]));
            chk("conflict", g, 32'(cf[g]), 32'(exp_cf));
            for (int i = 0; i < 4; i++) begin
                chk("lane_data", g, 32'(ld[g][i]), 32'(held_d[g][i]));
                chk("old_address", g, 32'(oa[g][i]), 32'(held_a[g][i]));
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] b0, input logic [1:0] b1,
                         input logic [1:0] b2, input logic [1:0] b3,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] a3);
        in_valid = v;
        bank[0] = b0; bank[1] = b1; bank[2] = b2; bank[3] = b3;
        na[0] = a0; na[1] = a1; na[2] = a2; na[3] = a3;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        int ovc;
        logic [6:0] av;
        fill(0);
        rst = 1'b0;
        clear = 1'b0;
        // garbage under reset, including a conflicting valid beat
        repeat (3) drive(1'b1, 2'd1, 2'd1, 2'd3, 2'd0, 5'd7, 5'd9, 5'd31, 5'd2);
        chk("rst_out_valid", 0, 32'(ov[0]), 32'd0);
        chk("rst_lane_data0", 0, 32'(ld[0][0]), 32'd0);
        chk("rst_old_addr3", 2, 32'(oa[2][3]), 32'd0);
        chk("rst_conflict", 1, 32'(cf[1]), 32'd0);
        rst = 1'b1;
        idle(4);
        chk("post_rst_idle", 2, 32'(ov[2]), 32'd0);

        // identity block, addresses 0..3
        drive(1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 5'd0, 5'd0, 5'd0, 5'd0);
        idle(1);
        chk("ident_valid", 0, 32'(ov[0]), 32'd1);
        chk("ident_ld0", 0, 32'(ld[0][0]), 32'hA00);
        chk("ident_ld1", 0, 32'(ld[0][1]), 32'hB11);
        chk("ident_ld2", 0, 32'(ld[0][2]), 32'hC22);
        chk("ident_ld3", 0, 32'(ld[0][3]), 32'hD33);
        chk("ident_oa3", 0, 32'(oa[0][3]), 32'd3);
        chk("ident_conflict", 0, 32'(cf[0]), 32'd0);

        // parity-rotated block, addresses 4..7
        drive(1'b1, 2'd2, 2'd3, 2'd0, 2'd1, 5'd1, 5'd1, 5'd1, 5'd1);
        idle(1);
        chk("rot_ld0", 0, 32'(ld[0][0]), 32'h300);
        chk("rot_ld1", 0, 32'(ld[0][1]), 32'h400);
        chk("rot_ld2", 0, 32'(ld[0][2]), 32'h100);
        chk("rot_ld3", 0, 32'(ld[0][3]), 32'h200);
        chk("rot_oa0", 0, 32'(oa[0][0]), 32'd4);
        chk("rot_oa2", 0, 32'(oa[0][2]), 32'd6);
        idle(6);

        // streaming, addresses 0..31, data = address*3
        fill(1);
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                drive(1'b1, fwd_bank(7'(4*k)), fwd_bank(7'(4*k+1)),
                      fwd_bank(7'(4*k+2)), fwd_bank(7'(4*k+3)),
                      5'(k), 5'(k), 5'(k), 5'(k));
            end else begin
                idle(1);
            end
            chk("stream_valid_l3", 2, 32'(ov[2]), 32'((k >= 3 && k <= 10) ? 1 : 0));
            if (k >= 3 && k <= 10) begin
                for (int i = 0; i < 4; i++) begin
                    av = 7'(4*(k-3) + i);
                    chk("stream_oa_l3", 2, 32'(oa[2][i]), 32'(av));
                    chk("stream_ld_l3", 2, 32'(ld[2][i]), 32'(av) * 3);
                end
            end
        end
        idle(4);

        // conflict: lanes 0 and 1 both on bank 1 (bank 1 is read at in-bank address 2)
        drive(1'b1, 2'd1, 2'd1, 2'd2, 2'd3, 5'd0, 5'd2, 5'd0, 5'd0);
        chk("conf_set", 2, 32'(cf[2]), 32'd1);
        idle(1);
        chk("conf_ld0", 0, 32'(ld[0][0]), 32'h21);
        chk("conf_ld1", 0, 32'(ld[0][1]), 32'h21);
        chk("conf_oa1", 0, 32'(oa[0][1]), 32'd11);
        idle(3);
        chk("conf_hold", 0, 32'(cf[0]), 32'd1);
        clear = 1'b1;
        drive(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        chk("conf_set_wins", 1, 32'(cf[1]), 32'd1);
        idle(1);
        clear = 1'b0;
        chk("conf_cleared", 1, 32'(cf[1]), 32'd0);
        idle(5);

        // reset with two beats in flight
        ovc = 0;
        drive(1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 5'd3, 5'd3, 5'd3, 5'd3);
        ovc += 32'(ov[1]);
        drive(1'b1, 2'd2, 2'd3, 2'd0, 2'd1, 5'd4, 5'd4, 5'd4, 5'd4);
        ovc += 32'(ov[1]);
        rst = 1'b0;
        idle(1);
        ovc += 32'(ov[1]);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            ovc += 32'(ov[1]);
        end
        chk("midrst_no_valid_l2", 1, 32'(ovc), 32'd0);
        drive(1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 5'd5, 5'd5, 5'd5, 5'd5);
        idle(1);
        chk("midrst_early_l2", 1, 32'(ov[1]), 32'd0);
        idle(1);
        chk("midrst_valid_l2", 1, 32'(ov[1]), 32'd1);
        chk("midrst_ld0_l2", 1, 32'(ld[1][0]), 32'd60);
        chk("midrst_oa3_l2", 1, 32'(oa[1][3]), 32'd23);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
